// File: rtl/phy_pkg.sv
// Shared definitions for the PHY TX word scheduler: idle symbol, link state
// encoding and the counter-width helper used by the scheduler and arbiter.
package phy_pkg;

  localparam logic [7:0] IDLE_SYM  = 8'hBC;
  localparam int         WORD_W    = 8;
  localparam int         BIT_IDX_W = 3;

  typedef enum logic {
    SYNC   = 1'b0,
    ACTIVE = 1'b1
  } tx_state_e;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_w(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tx_word_arbiter.sv
// Lane arbiter for the TX word scheduler: combinational grant between the two
// stripe requesters plus the burst counter that bounds lane-0 starvation of lane 1.
module tx_word_arbiter
  import phy_pkg::*;
#(
  parameter  int MAX_BURST = 4,
  localparam int BURST_W   = cnt_w(MAX_BURST)
) (
  input  logic clk_8f,
  input  logic reset,
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_skip_due,
  input  logic i_update,
  input  logic i_clear,
  output logic o_grant0,
  output logic o_grant1
);

  logic [BURST_W-1:0] r_burst_cnt;
  logic               w_burst_full;

  assign w_burst_full = (r_burst_cnt == BURST_W'(MAX_BURST));

  // Lane 1 wins when lane 0 is idle or has used up its burst; nobody wins a skip slot.
  always_comb begin
    // NOTE: every output gets a default first so no latch is inferred.
    o_grant0 = 1'b0;
    o_grant1 = 1'b0;
    if (!i_skip_due) begin
      if (i_valid1 && (!i_valid0 || w_burst_full)) begin
        o_grant1 = 1'b1;
      end else if (i_valid0) begin
        o_grant0 = 1'b1;
      end
    end
  end

  // Count consecutive lane-0 grants while lane 1 is waiting, saturating at MAX_BURST.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      r_burst_cnt <= '0;
    end else if (i_clear) begin
      r_burst_cnt <= '0;
    end else if (i_update) begin
      if (o_grant1 || !i_valid1) begin
        r_burst_cnt <= '0;
      end else if (o_grant0 && !w_burst_full) begin
        r_burst_cnt <= r_burst_cnt + BURST_W'(1);
      end
    end
  end

endmodule

// File: rtl/phy_tx_scheduler.sv
// TX word scheduler for the PHY serializer. Runs the bit-slot counter and, once
// per 8-cycle word, loads either a granted data byte or the idle symbol. Handles
// post-reset/enable sync words and periodic skip words for clock compensation.
module phy_tx_scheduler
  import phy_pkg::*;
#(
  parameter int SYNC_WORDS  = 4,
  parameter int SKIP_PERIOD = 64,
  parameter int MAX_BURST   = 4
) (
  input  logic                 clk_8f,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [WORD_W-1:0]    data0,
  input  logic                 valid0,
  output logic                 ready0,
  input  logic [WORD_W-1:0]    data1,
  input  logic                 valid1,
  output logic                 ready1,
  output logic [WORD_W-1:0]    data_out,
  output logic                 valid_out,
  output logic                 load_stb,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 lane_src,
  output logic                 sync_done
);

  localparam int SYNC_W = cnt_w(SYNC_WORDS - 1);
  localparam int SKIP_W = cnt_w(SKIP_PERIOD - 1);

  tx_state_e              r_state;
  logic [BIT_IDX_W-1:0]   r_bit_idx;
  logic [SYNC_W-1:0]      r_word_cnt;
  logic [SKIP_W-1:0]      r_skip_cnt;
  logic [WORD_W-1:0]      r_data_out;
  logic                   r_valid_out;
  logic                   r_load_stb;
  logic                   r_lane_src;

  logic w_boundary;
  logic w_in_active;
  logic w_active_slot;
  logic w_skip_due;
  logic w_grant0;
  logic w_grant1;

  assign w_boundary    = (r_bit_idx == BIT_IDX_W'(7));
  assign w_in_active   = (r_state == ACTIVE);
  assign w_active_slot = w_boundary && w_in_active && enable;
  assign w_skip_due    = (r_skip_cnt == SKIP_W'(SKIP_PERIOD - 1));

  tx_word_arbiter #(
    .MAX_BURST (MAX_BURST)
  ) u_arbiter (
    .clk_8f     (clk_8f),
    .reset      (reset),
    .i_valid0   (valid0),
    .i_valid1   (valid1),
    .i_skip_due (w_skip_due),
    .i_update   (w_active_slot),
    .i_clear    (w_boundary && w_in_active && !enable),
    .o_grant0   (w_grant0),
    .o_grant1   (w_grant1)
  );

  // Accept strobes exist only in the boundary cycle of an enabled ACTIVE word.
  assign ready0 = w_active_slot && w_grant0;
  assign ready1 = w_active_slot && w_grant1;

  // Bit-slot counter, link state machine and word-load registers.
  always_ff @(posedge clk_8f or posedge reset) begin
    if (reset) begin
      r_state     <= SYNC;
      r_bit_idx   <= '0;
      r_word_cnt  <= '0;
      r_skip_cnt  <= '0;
      r_data_out  <= IDLE_SYM;
      r_valid_out <= 1'b0;
      r_load_stb  <= 1'b0;
      r_lane_src  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      r_bit_idx  <= r_bit_idx + BIT_IDX_W'(1);
      r_load_stb <= w_boundary;
      if (w_boundary) begin
        r_data_out  <= IDLE_SYM;
        r_valid_out <= 1'b0;
        r_lane_src  <= 1'b0;
        unique case (r_state)
          SYNC: begin
            if (!enable) begin
              r_word_cnt <= '0;
            end else if (r_word_cnt == SYNC_W'(SYNC_WORDS - 1)) begin
              r_state    <= ACTIVE;
              r_word_cnt <= '0;
              r_skip_cnt <= '0;
            end else begin
              r_word_cnt <= r_word_cnt + SYNC_W'(1);
            end
          end
          ACTIVE: begin
            if (!enable) begin
              r_state    <= SYNC;
              r_word_cnt <= '0;
              r_skip_cnt <= '0;
            end else if (w_skip_due) begin
              r_skip_cnt <= '0;
            end else begin
              r_skip_cnt <= r_skip_cnt + SKIP_W'(1);
              if (w_grant1) begin
                r_data_out  <= data1;
                r_valid_out <= 1'b1;
                r_lane_src  <= 1'b1;
              end else if (w_grant0) begin
                r_data_out  <= data0;
                r_valid_out <= 1'b1;
                r_lane_src  <= 1'b0;
              end
            end
          end
          default: r_state <= SYNC;
        endcase
      end
    end
  end

  assign bit_idx   = r_bit_idx;
  assign data_out  = r_data_out;
  assign valid_out = r_valid_out;
  assign load_stb  = r_load_stb;
  assign lane_src  = r_lane_src;
  assign sync_done = w_in_active;

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Directed self-checking bench for phy_tx_scheduler (default parameters:
// SYNC_WORDS=4, SKIP_PERIOD=64, MAX_BURST=4).
module tb_phy_tx_scheduler;

  logic       clk_8f = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data0;
  logic       valid0;
  logic       ready0;
  logic [7:0] data1;
  logic       valid1;
  logic       ready1;
  logic [7:0] data_out;
  logic       valid_out;
  logic       load_stb;
  logic [2:0] bit_idx;
  logic       lane_src;
  logic       sync_done;

  int checks = 0;
  int errors = 0;

  phy_tx_scheduler dut (
    .clk_8f    (clk_8f),
    .reset     (reset),
    .enable    (enable),
    .data0     (data0),
    .valid0    (valid0),
    .ready0    (ready0),
    .data1     (data1),
    .valid1    (valid1),
    .ready1    (ready1),
    .data_out  (data_out),
    .valid_out (valid_out),
    .load_stb  (load_stb),
    .bit_idx   (bit_idx),
    .lane_src  (lane_src),
    .sync_done (sync_done)
  );

  always #5 clk_8f = ~clk_8f;

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  // One active edge, then sample 1 time unit later.
  task automatic tick();
    @(posedge clk_8f);
    #1;
  endtask

  // Assert reset with idle inputs and release it while the clock is low.
  task automatic apply_reset();
    reset  = 1'b1;
    enable = 1'b1;
    valid0 = 1'b0;
    valid1 = 1'b0;
    data0  = 8'h00;
    data1  = 8'h00;
    @(negedge clk_8f);
    @(negedge clk_8f);
    reset = 1'b0;
  endtask

  // Reset and run through the four sync words; ends just after edge 32 (bit_idx 0, ACTIVE).
  task automatic reset_sync();
    apply_reset();
    repeat (32) tick();
  endtask

  task automatic test_reset();
    logic [15:0] got;
    reset = 1'b1; enable = 1'b1;
    valid0 = 1'b1; valid1 = 1'b1; data0 = 8'h12; data1 = 8'h34;
    #1;
    got = {bit_idx, data_out, valid_out, load_stb, ready0, ready1, lane_src, sync_done};
    checks++;
    if (got !== {3'd0, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL reset_values got %h want %h", got, {3'd0, 8'hBC, 6'b0});
    end
    apply_reset();
    for (int n = 1; n <= 32; n++) begin
      tick();
      checks++;
      if ({bit_idx, load_stb, sync_done, valid_out, data_out} !==
          {3'(n % 8), (n % 8) == 0, n >= 32, 1'b0, 8'hBC}) begin
        errors++;
        $display("FAIL sync_edge%0d got idx=%0d stb=%b sd=%b vo=%b do=%h want idx=%0d stb=%b sd=%b vo=0 do=bc",
                 n, bit_idx, load_stb, sync_done, valid_out, data_out, n % 8, (n % 8) == 0, n >= 32);
      end
    end
  endtask

  task automatic test_single_byte();
    reset_sync();
    valid0 = 1'b1; data0 = 8'hA5;
    #1;
    checks++;
    if (ready0 !== 1'b0) begin
      errors++; $display("FAIL single_ready_idx0 got %b want 0", ready0);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if ({ready0, ready1} !== {k == 7, 1'b0}) begin
        errors++;
        $display("FAIL single_ready_idx%0d got r0=%b r1=%b want r0=%b r1=0", k, ready0, ready1, k == 7);
      end
    end
    tick();
    valid0 = 1'b0;
    checks++;
    if ({data_out, valid_out, lane_src, load_stb} !== {8'hA5, 1'b1, 1'b0, 1'b1}) begin
      errors++;
      $display("FAIL single_load got do=%h vo=%b ls=%b stb=%b want a5 1 0 1", data_out, valid_out, lane_src, load_stb);
    end
    for (int k = 1; k <= 7; k++) begin
      tick();
      checks++;
      if ({data_out, valid_out, load_stb, ready0} !== {8'hA5, 1'b1, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL single_hold%0d got do=%h vo=%b stb=%b r0=%b want a5 1 0 0", k, data_out, valid_out, load_stb, ready0);
      end
    end
    tick();
    checks++;
    if ({data_out, valid_out} !== {8'hBC, 1'b0}) begin
      errors++; $display("FAIL single_after got do=%h vo=%b want bc 0", data_out, valid_out);
    end
  endtask

  task automatic test_valid_drop();
    reset_sync();
    valid0 = 1'b1; data0 = 8'h3C;
    repeat (3) tick();
    valid0 = 1'b0;
    repeat (4) tick();
    checks++;
    if ({ready0, ready1} !== 2'b00) begin
      errors++; $display("FAIL drop_ready got %b%b want 00", ready0, ready1);
    end
    tick();
    checks++;
    if ({data_out, valid_out, lane_src} !== {8'hBC, 1'b0, 1'b0}) begin
      errors++; $display("FAIL drop_idle got do=%h vo=%b ls=%b want bc 0 0", data_out, valid_out, lane_src);
    end
    valid1 = 1'b1; data1 = 8'h5A;
    repeat (7) tick();
    checks++;
    if ({ready0, ready1} !== 2'b01) begin
      errors++; $display("FAIL lane1_ready got %b%b want 01", ready0, ready1);
    end
    tick();
    valid1 = 1'b0;
    checks++;
    if ({data_out, valid_out, lane_src} !== {8'h5A, 1'b1, 1'b1}) begin
      errors++; $display("FAIL lane1_load got do=%h vo=%b ls=%b want 5a 1 1", data_out, valid_out, lane_src);
    end
  endtask

  task automatic test_arbitration();
    logic exp_lane [10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    reset_sync();
    valid0 = 1'b1; data0 = 8'h11;
    valid1 = 1'b1; data1 = 8'h22;
    for (int w = 0; w < 10; w++) begin
      repeat (7) tick();
      checks++;
      if ({ready0, ready1} !== {!exp_lane[w], exp_lane[w]}) begin
        errors++;
        $display("FAIL arb_ready_w%0d got r0=%b r1=%b want r0=%b r1=%b", w, ready0, ready1, !exp_lane[w], exp_lane[w]);
      end
      tick();
      checks++;
      if ({lane_src, valid_out, data_out} !== {exp_lane[w], 1'b1, exp_lane[w] ? 8'h22 : 8'h11}) begin
        errors++;
        $display("FAIL arb_word%0d got ls=%b vo=%b do=%h want ls=%b vo=1", w, lane_src, valid_out, data_out, exp_lane[w]);
      end
    end
    valid0 = 1'b0; valid1 = 1'b0;
  endtask

  task automatic test_skip();
    reset_sync();
    valid0 = 1'b1; data0 = 8'hC3;
    for (int w = 1; w <= 65; w++) begin
      repeat (7) tick();
      checks++;
      if (ready0 !== (w != 64)) begin
        errors++; $display("FAIL skip_ready_w%0d got %b want %b", w, ready0, w != 64);
      end
      tick();
      checks++;
      if ({data_out, valid_out} !== ((w == 64) ? {8'hBC, 1'b0} : {8'hC3, 1'b1})) begin
        errors++;
        $display("FAIL skip_word%0d got do=%h vo=%b want %s", w, data_out, valid_out, (w == 64) ? "bc 0" : "c3 1");
      end
    end
    valid0 = 1'b0;
  endtask

  task automatic test_enable_drop();
    reset_sync();
    valid0 = 1'b1; data0 = 8'h77;
    repeat (8) tick();
    checks++;
    if ({data_out, valid_out} !== {8'h77, 1'b1}) begin
      errors++; $display("FAIL en_first got do=%h vo=%b want 77 1", data_out, valid_out);
    end
    repeat (3) tick();
    enable = 1'b0;
    repeat (4) tick();
    checks++;
    if (ready0 !== 1'b0) begin
      errors++; $display("FAIL en_ready_low got %b want 0", ready0);
    end
    tick();
    enable = 1'b1;
    checks++;
    if ({data_out, valid_out, sync_done} !== {8'hBC, 1'b0, 1'b0}) begin
      errors++; $display("FAIL en_drop got do=%h vo=%b sd=%b want bc 0 0", data_out, valid_out, sync_done);
    end
    for (int s = 1; s <= 4; s++) begin
      repeat (7) tick();
      checks++;
      if (ready0 !== 1'b0) begin
        errors++; $display("FAIL en_sync_ready%0d got %b want 0", s, ready0);
      end
      tick();
      checks++;
      if ({data_out, valid_out, sync_done} !== {8'hBC, 1'b0, s == 4}) begin
        errors++;
        $display("FAIL en_sync%0d got do=%h vo=%b sd=%b want bc 0 %b", s, data_out, valid_out, sync_done, s == 4);
      end
    end
    repeat (7) tick();
    checks++;
    if (ready0 !== 1'b1) begin
      errors++; $display("FAIL en_resume_ready got %b want 1", ready0);
    end
    tick();
    valid0 = 1'b0;
    checks++;
    if ({data_out, valid_out} !== {8'h77, 1'b1}) begin
      errors++; $display("FAIL en_resume got do=%h vo=%b want 77 1", data_out, valid_out);
    end
  endtask

  task automatic test_sync_restart();
    apply_reset();
    repeat (20) tick();
    enable = 1'b0;
    repeat (4) tick();
    enable = 1'b1;
    checks++;
    if (sync_done !== 1'b0) begin
      errors++; $display("FAIL restart_e24 got %b want 0", sync_done);
    end
    repeat (8) tick();
    checks++;
    if (sync_done !== 1'b0) begin
      errors++; $display("FAIL restart_e32 got %b want 0", sync_done);
    end
    repeat (23) tick();
    checks++;
    if (sync_done !== 1'b0) begin
      errors++; $display("FAIL restart_e55 got %b want 0", sync_done);
    end
    tick();
    checks++;
    if (sync_done !== 1'b1) begin
      errors++; $display("FAIL restart_e56 got %b want 1", sync_done);
    end
  endtask

  task automatic test_reset_mid_word();
    reset_sync();
    valid0 = 1'b1; data0 = 8'hA5;
    repeat (8) tick();
    valid0 = 1'b0;
    repeat (3) tick();
    checks++;
    if ({bit_idx, data_out, valid_out} !== {3'd3, 8'hA5, 1'b1}) begin
      errors++; $display("FAIL mid_pre got idx=%0d do=%h vo=%b want 3 a5 1", bit_idx, data_out, valid_out);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bit_idx, data_out, valid_out, load_stb, lane_src, sync_done, ready0} !==
        {3'd0, 8'hBC, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL mid_reset got idx=%0d do=%h vo=%b stb=%b ls=%b sd=%b r0=%b want 0 bc 0 0 0 0 0",
               bit_idx, data_out, valid_out, load_stb, lane_src, sync_done, ready0);
    end
    @(negedge clk_8f);
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_valid_drop();
    test_arbitration();
    test_skip();
    test_enable_drop();
    test_sync_restart();
    test_reset_mid_word();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
